midi_note_scheduler: RTL and testbench

Downstream consumer of the MIDI decode datapath. It buffers decoded events (note type, 10-bit delay, 8-bit velocity) in a small FIFO and releases each event after its delay has elapsed, counted in time-base ticks. The released event goes to the synth/voice stage over a valid/ready handshake. Events are strictly in order; each delay is measured from the moment that event reaches the head of the FIFO and is loaded.

---
 rtl/midi_note_scheduler.sv | 172 +++++++++++++++++
 tb/tb_midi_note_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_scheduler.sv
// midi_note_scheduler
//   Buffers decoded MIDI events {type, delay, velocity} in a FIFO and releases
//   each one to the voice stage after its delay, counted in time-base ticks,
//   has elapsed. Events leave strictly in order. The delay of an event starts
//   counting when that event is popped from the FIFO head into the current
//   slot.
//
//   Optional build macro: SCHED_TICK_PRESCALE_EN
//     defined   : an internal prescaler produces one tick every TICK_DIV
//                 cycles and the tick port is ignored.
//     undefined : the tick port is the time base.
//
// Ports
//   Clock, Reset                   clock, asynchronous active-low reset
//   messageValid/Type, delay, veloc decoded event input (pushed when accepted)
//   tick                           single-cycle time-base strobe
//   clrOverflow                    clears the sticky overflow flag
//   inReady                        FIFO not full
//   outValid/outReady              release handshake to the voice stage
//   outType, outVeloc              released event payload
//   fifoCount                      occupied FIFO entries
//   busy                           scheduler FSM not idle
//   overflow                       sticky: an input event was dropped
module midi_note_scheduler #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   messageValid,
  input  logic                   messageType,
  input  logic [9:0]             delay,
  input  logic [7:0]             veloc,
  input  logic                   tick,
  input  logic                   clrOverflow,
  output logic                   inReady,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   outType,
  output logic [7:0]             outVeloc,
  output logic [$clog2(DEPTH):0] fifoCount,
  output logic                   busy,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t           state;
  state_t           nextState;
  logic [18:0]      mem [DEPTH];
  logic [18:0]      headEntry;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic [9:0]       cnt;
  logic             curType;
  logic [7:0]       curVeloc;
  logic             tickEff;
  logic             push;
  logic             pop;
  logic             drop;

`ifdef SCHED_TICK_PRESCALE_EN
  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] preCnt;

  // Free-running prescaler; the tick is the cycle holding the last count.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      preCnt <= '0;
    end else if (preCnt == PRE_LAST) begin
      preCnt <= '0;
    end else begin
      preCnt <= preCnt + 1'b1;
    end
  end

  assign tickEff = (preCnt == PRE_LAST);
`else
  assign tickEff = tick;
`endif

  // A pop only happens from IDLE, so a full FIFO can still take an event in
  // the load cycle: the freed head slot is reused.
  assign pop       = (state == IDLE) && (count != '0);
  assign push      = messageValid && ((count != FULL_COUNT) || pop);
  assign drop      = messageValid && !push;
  assign headEntry = mem[rdPtr];
  assign inReady   = (count != FULL_COUNT);
  assign fifoCount = count;
  assign outType   = curType;
  assign outVeloc  = curVeloc;

  // FIFO storage carries no reset; only pointers and occupancy do.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wrPtr] <= {messageType, delay, veloc};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Current event slot and delay counter. A tick seen with cnt already at 0
  // is ignored; the FSM leaves WAIT on that cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      curType  <= 1'b0;
      curVeloc <= '0;
      cnt      <= '0;
    end else if (pop) begin
      curType  <= headEntry[18];
      cnt      <= headEntry[17:8];
      curVeloc <= headEntry[7:0];
    end else if ((state == WAIT) && (cnt != '0) && tickEff) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clrOverflow) begin
      overflow <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (count != '0) nextState = WAIT;
      WAIT:    if (cnt == '0)   nextState = ISSUE;
      ISSUE:   if (outReady)    nextState = IDLE;
      default:                  nextState = IDLE;
    endcase
  end

  // FSM outputs: pure state decode, no input feed-through.
  always_comb begin
    outValid = (state == ISSUE);
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_midi_note_scheduler.sv
// Testbench for midi_note_scheduler (DEPTH = 8).
// Vector table: single events with a given tick period and hand-computed
// release latency, counted in clock edges from the capture edge E.
// Ticks are presented on edges E+1+P*j (j >= 1); the load happens at E+1, so
// an event of delay d becomes visible on outValid after edge E+2+P*d.
module tb_midi_note_scheduler;

  localparam int DEPTH = 8;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       messageValid = 1'b0;
  logic       messageType = 1'b0;
  logic [9:0] delay = '0;
  logic [7:0] veloc = '0;
  logic       tick = 1'b0;
  logic       clrOverflow = 1'b0;
  logic       inReady;
  logic       outValid;
  logic       outReady = 1'b0;
  logic       outType;
  logic [7:0] outVeloc;
  logic [3:0] fifoCount;
  logic       busy;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  midi_note_scheduler #(.DEPTH(DEPTH), .TICK_DIV(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .messageValid(messageValid), .messageType(messageType),
    .delay(delay), .veloc(veloc), .tick(tick), .clrOverflow(clrOverflow),
    .inReady(inReady), .outValid(outValid), .outReady(outReady),
    .outType(outType), .outVeloc(outVeloc), .fifoCount(fifoCount),
    .busy(busy), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit         typ;
    int         dly;
    logic [7:0] vel;
    int         period;
    int         expL;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Presents one event for exactly one edge.
  task automatic pushEvent(input bit t, input int d, input logic [7:0] v);
    messageValid = 1'b1;
    messageType  = t;
    delay        = 10'(d);
    veloc        = v;
    step();
    messageValid = 1'b0;
  endtask

  task automatic runEvent(input string name, input bit t, input int d,
                          input logic [7:0] v, input int period, input int expL);
    int n;
    n = 0;
    outReady = 1'b1;
    pushEvent(t, d, v);
    check({name, "_countAfterPush"}, 32'(fifoCount), 32'd1);
    for (int k = 1; k <= 400 && n == 0; k++) begin
      tick = (k >= 2) && (((k - 1) % period) == 0);
      step();
      tick = 1'b0;
      if (outValid) n = k;
    end
    check({name, "_latency"}, 32'(n), 32'(expL));
    check({name, "_outType"}, 32'(outType), 32'(t));
    check({name, "_outVeloc"}, 32'(outVeloc), 32'(v));
    check({name, "_countEmpty"}, 32'(fifoCount), 32'd0);
    step();
    check({name, "_busyAfterHs"}, 32'(busy), 32'd0);
    check({name, "_validAfterHs"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] expVel [9];
    bit         expTyp [9];
    int         idx;
    int         n;

    vecs[0] = '{typ: 1'b1, dly: 0, vel: 8'h40, period: 1,  expL: 2};
    vecs[1] = '{typ: 1'b0, dly: 3, vel: 8'h7F, period: 10, expL: 32};
    vecs[2] = '{typ: 1'b1, dly: 5, vel: 8'h00, period: 1,  expL: 7};
    vecs[3] = '{typ: 1'b0, dly: 1, vel: 8'hFF, period: 3,  expL: 5};
    vecs[4] = '{typ: 1'b1, dly: 2, vel: 8'h81, period: 4,  expL: 10};
    vecs[5] = '{typ: 1'b0, dly: 4, vel: 8'h55, period: 2,  expL: 10};

    // Values held during reset.
    #12;
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_outType", 32'(outType), 32'd0);
    check("rst_outVeloc", 32'(outVeloc), 32'd0);
    check("rst_inReady", 32'(inReady), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifoCount", 32'(fifoCount), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    step();

`ifndef SCHED_TICK_PRESCALE_EN
    for (int i = 0; i < 6; i++) begin
      runEvent($sformatf("vec%0d", i), vecs[i].typ, vecs[i].dly, vecs[i].vel,
               vecs[i].period, vecs[i].expL);
    end
`else
    // Prescaled time base: delay 2 at 4 cycles/tick, tick port toggled.
    outReady = 1'b1;
    pushEvent(1'b1, 2, 8'h44);
    n = 0;
    for (int k = 1; k <= 200 && n == 0; k++) begin
      tick = k[0];
      step();
      if (outValid) n = k;
    end
    tick = 1'b0;
    check("pre_releaseWindow", 32'((n >= 5) && (n <= 13)), 32'd1);
    check("pre_outVeloc", 32'(outVeloc), 32'h44);
    step();
    check("pre_busyAfterHs", 32'(busy), 32'd0);
`endif

    // Output holds while the consumer stalls.
    outReady = 1'b0;
    pushEvent(1'b1, 0, 8'h33);
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hold%0d_outValid", k), 32'(outValid), 32'd1);
      check($sformatf("hold%0d_outVeloc", k), 32'(outVeloc), 32'h33);
      check($sformatf("hold%0d_outType", k), 32'(outType), 32'd1);
      step();
    end
    outReady = 1'b1;
    step();
    check("hold_busyAfterHs", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a long WAIT.
    pushEvent(1'b1, 500, 8'h22);
    pushEvent(1'b0, 7, 8'h23);
    for (int k = 0; k < 100; k++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
    check("midWait_busy", 32'(busy), 32'd1);
    check("midWait_outValid", 32'(outValid), 32'd0);
    check("midWait_count", 32'(fifoCount), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("inRst_outValid", 32'(outValid), 32'd0);
    check("inRst_busy", 32'(busy), 32'd0);
    check("inRst_fifoCount", 32'(fifoCount), 32'd0);
    check("inRst_outVeloc", 32'(outVeloc), 32'd0);
    check("inRst_inReady", 32'(inReady), 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    step();
    check("postRst_outValid", 32'(outValid), 32'd0);
    check("postRst_fifoCount", 32'(fifoCount), 32'd0);
    check("postRst_busy", 32'(busy), 32'd0);
    runEvent("postRst", 1'b0, 0, 8'h66, 1, 2);

    // Fill: first event moves into the current slot, eight more fill the FIFO.
    outReady = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pushEvent(1'(i), 0, 8'(8'h10 + i));
    end
    check("full_count", 32'(fifoCount), 32'd8);
    check("full_inReady", 32'(inReady), 32'd0);
    check("full_overflowClear", 32'(overflow), 32'd0);
    check("full_outValid", 32'(outValid), 32'd1);
    check("full_outVeloc", 32'(outVeloc), 32'h10);
    pushEvent(1'b0, 0, 8'h99);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_count", 32'(fifoCount), 32'd8);
    clrOverflow = 1'b1;
    step();
    clrOverflow = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
    clrOverflow = 1'b1;
    pushEvent(1'b0, 0, 8'h98);
    clrOverflow = 1'b0;
    check("setWins_overflow", 32'(overflow), 32'd1);
    clrOverflow = 1'b1;
    step();
    clrOverflow = 1'b0;
    check("clr2_overflow", 32'(overflow), 32'd0);

    // Release the head, then push into the full FIFO on the IDLE load edge.
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    check("idleFull_busy", 32'(busy), 32'd0);
    check("idleFull_count", 32'(fifoCount), 32'd8);
    pushEvent(1'b1, 0, 8'h19);
    check("pushPop_count", 32'(fifoCount), 32'd8);
    check("pushPop_overflow", 32'(overflow), 32'd0);
    check("pushPop_busy", 32'(busy), 32'd1);

    // Drain: order 0x11..0x19 across the pointer wrap, dropped ones absent.
    for (int i = 0; i < 9; i++) begin
      expVel[i] = 8'(8'h11 + i);
      expTyp[i] = 1'((i + 1) & 1);
    end
    idx = 0;
    outReady = 1'b1;
    for (int k = 0; k < 100 && idx < 9; k++) begin
      step();
      if (outValid) begin
        check($sformatf("drain%0d_outVeloc", idx), 32'(outVeloc), 32'(expVel[idx]));
        check($sformatf("drain%0d_outType", idx), 32'(outType), 32'(expTyp[idx]));
        idx++;
      end
    end
    check("drain_events", 32'(idx), 32'd9);
    step();
    check("drain_countEmpty", 32'(fifoCount), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
